ex_muldiv: RTL

Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. EX hands it the operands of any M-extension instruction; the block then runs a multi-cycle shift-add or restoring-divide sequence. While it runs, it holds the pipeline through `stallreq_o`. On completion it presents the result plus destination-register info for one cycle, and EX forwards that in place of the ALU answer.

---
 rtl/ex_muldiv.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle 33x33 multiply in place of shift-add.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    input  logic            flush_i,
    output logic            stallreq_o,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);
    localparam int               ACC_W     = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]       OP_MUL    = 3'd0;
    localparam logic [2:0]       OP_MULH   = 3'd1;
    localparam logic [2:0]       OP_MULHSU = 3'd2;
    localparam logic [2:0]       OP_DIV    = 3'd4;
    localparam logic [2:0]       OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [XLEN-1:0]   opb_reg, opb_next;
    logic [2:0]        op_reg, op_next;
    logic              neg_reg, neg_next;
    logic              rneg_reg, rneg_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic [4:0]        wd_reg, wd_next;
    logic              wreg_reg, wreg_next;

    // Operand decode for the request presented this cycle.
    logic              sign1, sign2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic              div_zero, div_ovf;

    assign sign1    = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                      (op_i == OP_DIV)  || (op_i == OP_REM);
    assign sign2    = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign neg1     = sign1 & reg1_i[XLEN-1];
    assign neg2     = sign2 & reg2_i[XLEN-1];
    assign mag1     = neg1 ? -reg1_i : reg1_i;
    assign mag2     = neg2 ? -reg2_i : reg2_i;
    assign div_zero = (reg2_i == '0);
    assign div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (reg1_i == INT_MIN) && (&reg2_i);

    // One shift-add step: acc = {partial high, remaining multiplier bits}.
    logic [XLEN:0]     mul_sum;
    logic [ACC_W-1:0]  mul_step, mul_fix;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, acc_reg[ACC_W-1:XLEN]} + (acc_reg[0] ? {1'b0, opb_reg} : '0);
    assign mul_step = {mul_sum, acc_reg[XLEN-1:1]};
    assign mul_fix  = neg_reg ? -mul_step : mul_step;
    assign mul_res  = (op_reg == OP_MUL) ? mul_fix[XLEN-1:0] : mul_fix[ACC_W-1:XLEN];

    // One restoring-divide step: acc = {partial remainder, dividend/quotient bits}.
    logic [XLEN:0]     div_trial;
    logic [ACC_W-1:0]  div_step;
    logic [XLEN-1:0]   quo_raw, rem_raw, div_res;

    assign div_trial = acc_reg[ACC_W-1:XLEN-1] - {1'b0, opb_reg};
    assign div_step  = div_trial[XLEN] ? {acc_reg[ACC_W-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
    assign quo_raw   = div_step[XLEN-1:0];
    assign rem_raw   = div_step[ACC_W-1:XLEN];
    assign div_res   = op_reg[1] ? (rneg_reg ? -rem_raw : rem_raw)
                                 : (neg_reg  ? -quo_raw : quo_raw);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0] fast_a, fast_b;
    logic [ACC_W-1:0]     fast_prod;
    logic [XLEN-1:0]      fast_res;

    assign fast_a    = $signed({neg1, reg1_i});
    assign fast_b    = $signed({neg2, reg2_i});
    assign fast_prod = ACC_W'(fast_a * fast_b);
    assign fast_res  = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[ACC_W-1:XLEN];
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        opb_next   = opb_reg;
        op_next    = op_reg;
        neg_next   = neg_reg;
        rneg_next  = rneg_reg;
        wdata_next = wdata_reg;
        wd_next    = wd_reg;
        wreg_next  = wreg_reg;

        if (flush_i) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start_i) begin
                        op_next   = op_i;
                        wd_next   = wd_i;
                        wreg_next = wreg_i;
                        neg_next  = neg1 ^ neg2;
                        rneg_next = neg1;
                        cnt_next  = '0;
                        if (!op_i[2]) begin
`ifdef MULDIV_FAST_MUL_EN
                            wdata_next = fast_res;
                            state_next = S_DONE;
`else
                            opb_next   = mag1;
                            acc_next   = {{XLEN{1'b0}}, mag2};
                            state_next = S_MUL;
`endif
                        end else if (div_zero) begin
                            wdata_next = op_i[1] ? reg1_i : '1;
                            state_next = S_DONE;
                        end else if (div_ovf) begin
                            wdata_next = op_i[1] ? '0 : INT_MIN;
                            state_next = S_DONE;
                        end else begin
                            opb_next   = mag2;
                            acc_next   = {{XLEN{1'b0}}, mag1};
                            state_next = S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    acc_next = mul_step;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        wdata_next = mul_res;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                S_DIV: begin
                    acc_next = div_step;
                    if (cnt_reg == CNT_LAST) begin
                        cnt_next   = '0;
                        wdata_next = div_res;
                        state_next = S_DONE;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            opb_reg   <= '0;
            op_reg    <= '0;
            neg_reg   <= 1'b0;
            rneg_reg  <= 1'b0;
            wdata_reg <= '0;
            wd_reg    <= '0;
            wreg_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            opb_reg   <= opb_next;
            op_reg    <= op_next;
            neg_reg   <= neg_next;
            rneg_reg  <= rneg_next;
            wdata_reg <= wdata_next;
            wd_reg    <= wd_next;
            wreg_reg  <= wreg_next;
        end
    end

    // A flush silences the hold request and any result in the same cycle.
    assign busy_o     = (state_reg == S_MUL) || (state_reg == S_DIV);
    assign stallreq_o = ~flush_i & (((state_reg == S_IDLE) & start_i) | busy_o);
    assign ready_o    = (state_reg == S_DONE) & ~flush_i;
    assign wdata_o    = wdata_reg;
    assign wd_o       = wd_reg;
    assign wreg_o     = wreg_reg & ready_o;

endmodule
